// File: rtl/qduc_interpolator_if.sv
// Baseband I/Q handshake and full-rate output bundle for qduc_interpolator.
// master = producer/consumer side, slave = interpolator.
interface qduc_interpolator_if #(
   parameter int ISZ = 16,
   parameter int OSZ = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic signed [ISZ-1:0] in_i;
   logic signed [ISZ-1:0] in_q;
   logic                  iq_swap;
   logic                  underrun;
   logic                  out_valid;
   logic signed [OSZ-1:0] out_i;
   logic signed [OSZ-1:0] out_q;

   modport master (
      output in_valid, in_i, in_q, iq_swap,
      input  in_ready, underrun, out_valid, out_i, out_q
   );

   modport slave (
      input  in_valid, in_i, in_q, iq_swap,
      output in_ready, underrun, out_valid, out_i, out_q
   );
endinterface

// File: rtl/qduc_interpolator.sv
// Transmit-side I/Q interpolator: 2-entry input FIFO, x32 four-stage CIC per
// channel with unity DC gain, full-rate output every clk.
module qduc_interpolator #(
   parameter int ISZ   = 16,
   parameter int OSZ   = 16,
   parameter int CICSZ = 31
) (
   input logic                clk,
   input logic                reset,
   qduc_interpolator_if.slave bus
);
   localparam int USZ = ISZ + 4;

   logic [4:0]              phase_q, phase_d;
   logic [1:0]              count_q, count_d;
   logic signed [ISZ-1:0]   fifo_q  [2][2], fifo_d  [2][2];  // [entry][channel]
   logic signed [USZ-1:0]   dly_q   [2][4], dly_d   [2][4];
   logic signed [USZ-1:0]   ups_q   [2],    ups_d   [2];
   logic signed [CICSZ-1:0] stuff_q [2],    stuff_d [2];
   logic signed [CICSZ-1:0] integ_q [2][4], integ_d [2][4];
   logic signed [OSZ-1:0]   dout_q  [2],    dout_d  [2];
   logic [5:0]              vld_q, vld_d;
   logic                    out_valid_q, out_valid_d;

   logic                    tick, pop, push;
   logic signed [ISZ-1:0]   samp [2];
   logic signed [USZ-1:0]   cv   [2][5];

   assign tick          = (phase_q == 5'd31);
   assign pop           = tick && (count_q != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign bus.in_ready  = !reset && (count_q != 2'd2);
   assign bus.underrun  = !reset && tick && (count_q == 2'd0);
   assign bus.out_valid = out_valid_q;
   assign bus.out_i     = dout_q[0];
   assign bus.out_q     = dout_q[1];

   // Channel 0 feeds the I chain, channel 1 the Q chain; an underrun feeds zeros.
   always_comb begin
      samp = '{default: '0};
      if (pop) begin
         samp[0] = bus.iq_swap ? fifo_q[0][1] : fifo_q[0][0];
         samp[1] = bus.iq_swap ? fifo_q[0][0] : fifo_q[0][1];
      end
   end

   always_comb begin
      phase_d = phase_q + 5'd1;
      count_d = count_q;
      fifo_d  = fifo_q;
      if (pop) begin
         fifo_d[0] = fifo_q[1];
         count_d   = count_q - 2'd1;
      end
      // Push lands behind whatever survives the pop, so order is preserved.
      if (push) begin
         fifo_d[count_d[0]][0] = bus.in_i;
         fifo_d[count_d[0]][1] = bus.in_q;
         count_d               = count_d + 2'd1;
      end
      vld_d       = {vld_q[4:0], vld_q[0] | pop};
      out_valid_d = vld_q[5];
   end

   always_comb begin
      cv      = '{default: '0};
      dly_d   = dly_q;
      ups_d   = ups_q;
      stuff_d = '{default: '0};
      integ_d = integ_q;
      dout_d  = dout_q;
      for (int unsigned c = 0; c < 2; c++) begin
         cv[c][0] = {{(USZ-ISZ){samp[c][ISZ-1]}}, samp[c]};
         for (int unsigned k = 0; k < 4; k++) begin
            cv[c][k+1] = cv[c][k] - dly_q[c][k];
            if (tick) dly_d[c][k] = cv[c][k];
         end
         if (tick) ups_d[c] = cv[c][4];
         // Zero stuffing: U enters the integrators only in the cycle after a tick.
         if (phase_q == 5'd0)
            stuff_d[c] = {{(CICSZ-USZ){ups_q[c][USZ-1]}}, ups_q[c]};
         integ_d[c][0] = integ_q[c][0] + stuff_q[c];
         for (int unsigned k = 1; k < 4; k++)
            integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
         dout_d[c] = integ_q[c][3][CICSZ-1 -: OSZ];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q     <= '0;
         count_q     <= '0;
         fifo_q      <= '{default: '0};
         dly_q       <= '{default: '0};
         ups_q       <= '{default: '0};
         stuff_q     <= '{default: '0};
         integ_q     <= '{default: '0};
         dout_q      <= '{default: '0};
         vld_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         count_q     <= count_d;
         fifo_q      <= fifo_d;
         dly_q       <= dly_d;
         ups_q       <= ups_d;
         stuff_q     <= stuff_d;
         integ_q     <= integ_d;
         dout_q      <= dout_d;
         vld_q       <= vld_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_qduc_interpolator.sv
// Bench for qduc_interpolator: queue-based FIFO model plus CIC impulse-response
// convolution, checked against the DUT every cycle, with directed scenarios.
module tb_qduc_interpolator;
   localparam int ISZ = 16;
   localparam int OSZ = 16;
   localparam int HLEN = 125;

   logic clk = 1'b0;
   logic reset;

   qduc_interpolator_if #(.ISZ(ISZ), .OSZ(OSZ)) bus ();

   qduc_interpolator #(.ISZ(ISZ), .OSZ(OSZ), .CICSZ(31)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { longint i; longint q; } pair_t;
   typedef struct { int t; longint i; longint q; } samp_t;

   pair_t  fq[$];
   samp_t  sq[$];
   longint h[HLEN];
   int     ph;
   int     tcnt;
   int     first_pop = -1;
   bit     model_ok  = 1'b0;

   // Output after edge tcnt = floor(sum x_k * h[tcnt-6-T_k] / 2^15).
   function automatic longint model_out(input bit ch);
      longint acc;
      int     d;
      acc = 0;
      foreach (sq[k]) begin
         d = tcnt - 6 - sq[k].t;
         if (d >= 0 && d < HLEN) acc += (ch ? sq[k].q : sq[k].i) * h[d];
      end
      return acc >>> 15;
   endfunction

   initial begin : model
      longint tmp[HLEN];
      pair_t  p;
      bit     rdy;
      // Impulse response of four cascaded length-32 boxcars.
      foreach (h[i]) h[i] = 0;
      h[0] = 1;
      for (int s = 0; s < 4; s++) begin
         foreach (tmp[i]) begin
            tmp[i] = 0;
            for (int j = 0; j < 32; j++) if (i - j >= 0) tmp[i] += h[i-j];
         end
         h = tmp;
      end
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("in_ready",  bus.in_ready,  !reset && fq.size() < 2);
            chk("underrun",  bus.underrun,  !reset && ph == 31 && fq.size() == 0);
            chk("out_valid", bus.out_valid, first_pop >= 0 && tcnt >= first_pop + 6);
            chk("out_i",     bus.out_i,     model_out(1'b0));
            chk("out_q",     bus.out_q,     model_out(1'b1));
         end
         @(posedge clk);
         if (reset) begin
            fq.delete();
            sq.delete();
            ph        = 0;
            tcnt      = 0;
            first_pop = -1;
            model_ok  = 1'b1;
         end else if (model_ok) begin
            rdy = fq.size() < 2;
            tcnt++;
            if (ph == 31 && fq.size() > 0) begin
               p = fq.pop_front();
               if (bus.iq_swap) sq.push_back('{tcnt, p.q, p.i});
               else             sq.push_back('{tcnt, p.i, p.q});
               if (first_pop < 0) first_pop = tcnt;
            end
            if (bus.in_valid && rdy) fq.push_back('{longint'(bus.in_i), longint'(bus.in_q)});
            ph = (ph + 1) % 32;
            while (sq.size() > 0 && tcnt - 6 - sq[0].t >= HLEN) void'(sq.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drive(input logic v, input int i, input int q, input logic sw);
      bus.in_valid = v;
      bus.in_i     = 16'(i);
      bus.in_q     = 16'(q);
      bus.iq_swap  = sw;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin : stim
      int     k;
      int     dens;
      logic   fire;
      longint gsum;
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("ready_after_reset", bus.in_ready, 1);

      // DC gain
      drive(1'b1, 1000, -1000, 1'b0);
      cyc(300);
      chk("dc_i", bus.out_i, 1000);
      chk("dc_q", bus.out_q, -1000);
      chk("dc_valid", bus.out_valid, 1);

      // Ordered ramp through the FIFO
      k = 1;
      for (int c = 0; c < 400; c++) begin
         bus.in_i = 16'(k);
         bus.in_q = 16'(-k);
         #1 fire = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #2;
         if (fire) k++;
      end

      // Full scale
      drive(1'b1, 32767, -32768, 1'b0);
      cyc(300);
      chk("fs_i", bus.out_i, 32767);
      chk("fs_q", bus.out_q, -32768);

      // Randomized traffic with varying density (sparse bursts force underruns)
      dens = 40;
      for (int c = 0; c < 2000; c++) begin
         if (c % 250 == 0) dens = $urandom_range(1, 40);
         drive(($urandom_range(0, 39) < dens), $urandom_range(0, 65535),
               $urandom_range(0, 65535), 1'($urandom_range(0, 1)));
         cyc(1);
      end

      // Reset mid-stream
      drive(1'b1, 1000, -1000, 1'b0);
      cyc(300);
      pulse_reset();
      #1;
      chk("rst_out_i", bus.out_i, 0);
      chk("rst_out_q", bus.out_q, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      cyc(37);
      chk("valid_edge37", bus.out_valid, 0);
      cyc(1);
      chk("valid_edge38", bus.out_valid, 1);
      cyc(150);
      chk("rst_dc_i", bus.out_i, 1000);

      // Single sample then starvation
      pulse_reset();
      drive(1'b1, 5000, 0, 1'b0);
      cyc(1);
      bus.in_valid = 1'b0;
      cyc(500);
      chk("decay_i", bus.out_i, 0);
      chk("decay_q", bus.out_q, 0);
      chk("decay_valid", bus.out_valid, 1);

      // I/Q swap
      drive(1'b1, 1000, 0, 1'b1);
      cyc(300);
      chk("swap_i", bus.out_i, 0);
      chk("swap_q", bus.out_q, 1000);

      // Pin the model's impulse response
      chk("h0", h[0], 1);
      chk("h1", h[1], 4);
      chk("h2", h[2], 10);
      chk("h124", h[124], 1);
      gsum = 0;
      foreach (h[i]) gsum += h[i];
      chk("h_sum", gsum, 1048576);
      gsum = 0;
      for (int m = 0; m < 4; m++) gsum += h[5 + 32*m];
      chk("h_phase_gain", gsum, 32768);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/qduc_interpolator.md
# qduc_interpolator

Transmit-side counterpart of the quadrature downconverter's decimation chain. It accepts baseband I/Q pairs through a valid/ready handshake and holds them in a 2-entry FIFO. It interpolates each channel by 32 with a 4-stage CIC interpolator and delivers full-rate I/Q every clk to the transmit tuner/mixer. Gain is exactly unity: a DC input yields the same DC output.

## Interface
- ISZ, 16, input word size (signed)
- OSZ, 16, output word size (signed)
- CICSZ, 31, CIC internal width = ISZ + 15 (N=4, R=32, M=1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  FIFO can accept a pair
- in_i  in  ISZ  in-phase input, signed
- in_q  in  ISZ  quadrature input, signed
- iq_swap  in  1  exchange I and Q at FIFO pop
- underrun  out  1  one-cycle pulse: tick with empty FIFO
- out_valid  out  1  output stream live
- out_i  out  OSZ  in-phase output, signed
- out_q  out  OSZ  quadrature output, signed

## Operation
- Reset values:
  - in_ready=0 during reset, 1 the first cycle after.
  - underrun=0, out_valid=0, out_i=out_q=0.
  - Phase counter=0, FIFO empty; all comb, integrator and delay registers 0.
- Phase counter: 5-bit, increments every clk, wraps 31→0. Tick = (phase==31), i.e. one tick per 32 clk.
- FIFO:
  - Depth 2; in_ready = (count<2).
  - Push on in_valid && in_ready.
  - Pop only on tick edges, when count>0.
  - Push and pop on the same edge: count unchanged, data order preserved.
  - Push when full is impossible, because in_ready=0.
- Underrun: on a tick with an empty FIFO, feed 0 to both comb chains and pulse underrun for that cycle. No stall, no repeat of the previous sample.
- iq_swap: sampled at the pop edge. When 1, the popped in_q feeds the I chain and in_i feeds the Q chain.
- Comb section (low rate, per channel):
  - 4 cascaded combs y = x − x[n−1], differential delay 1.
  - Evaluated combinationally from the popped sample.
  - The delay registers and the upsample register U (17+3 = 20 bits, sign-extended) are written only on tick edges.
- Zero stuffing:
  - The integrator input equals U for the single cycle after a tick edge.
  - It is 0 in the other 31 cycles.
- Integrator section (full rate): 4 cascaded registered integrators.
  - Each is CICSZ bits wide, updated every clk, with two's-complement wrap-around.
  - Stage k adds the registered output of stage k−1.
- Output:
  - out_x <= integrator4[30:15], registered every clk, truncation (no rounding).
  - Gain R^(N−1) = 2^15 is removed exactly, so no saturation is required.
- out_valid: set 6 edges after the first successful pop following reset; remains 1 until reset, including across underruns.

## Timing
- Throughput: one pair per 32 clk. in_ready drops only if the producer runs ahead by 2.
- Latency: a sample popped at tick edge E first affects out_i/out_q at edge E+6. The path is U at E, then 4 integrators at E+2..E+5, then the output register at E+6.
- Step settling: output reaches its final DC value within 4 low-rate periods (128 clk) plus 6 clk after the step is popped.
- The first tick occurs at the 32nd edge after reset deassertion.
- Reset mid-operation:
  - Takes effect on the next edge; all state returns to its reset values and FIFO contents are discarded.
  - The phase counter restarts at 0.

## Test plan
- DC gain: continuous in_i=1000, in_q=−1000 with in_valid=1. After at most 140 clk from first pop, out_i=1000 and out_q=−1000 every cycle; underrun never asserts.
- Full scale: constant in_i=32767, in_q=−32768. Outputs settle exactly to 32767 and −32768 with no wrap glitch at any cycle.
- Handshake and FIFO:
  - Hold in_valid=1 from reset release: in_ready=0 after 2 pushes, then reasserts for one cycle after each tick.
  - Feed values 1,2,3,… and check the low-rate steady state follows the same order with no drops or duplicates.
- Underrun: supply one pair (5000, 0), then stop. underrun pulses on every later tick, and out_i decays back to exactly 0.
- iq_swap: constant (1000, 0) with iq_swap=1. Outputs settle to out_i=0 and out_q=1000.
- Reset mid-stream: assert reset for 1 cycle during DC=1000 operation. Next cycle: outputs 0, out_valid=0, in_ready=1. out_valid rises 6 edges after the next pop.
